lu_seq: RTL



---
 rtl/lu_seq_pkg.sv | 19 +
 rtl/cl_bit.sv | 33 +++
 rtl/lu_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lu_seq_pkg.sv
// rtl/lu_seq_pkg.sv - op codes and FSM state encoding shared by lu_seq and cl_bit
package lu_seq_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NOTA  = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;
  localparam logic [2:0] OP_XNOR  = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/cl_bit.sv
// rtl/cl_bit.sv - 1-bit eight-way logic cell: shared gates feeding an 8:1 mux
module cl_bit
  import lu_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       out
);

  logic g_and;
  logic g_or;
  logic g_xor;

  assign g_and = a & b;
  assign g_or  = a | b;
  assign g_xor = a ^ b;

  always_comb begin
    out = 1'b0;
    case (op)
      OP_AND:   out = g_and;
      OP_OR:    out = g_or;
      OP_XOR:   out = g_xor;
      OP_NOTA:  out = ~a;
      OP_NAND:  out = ~g_and;
      OP_NOR:   out = ~g_or;
      OP_XNOR:  out = ~g_xor;
      OP_PASSB: out = b;
    endcase
  end

endmodule

// File: rtl/lu_seq.sv
// rtl/lu_seq.sv - W-bit logic unit with accumulator, parallel or bit-serial execution
module lu_seq
  import lu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  input  logic         ser,
  input  logic         acc_sel,
  input  logic         acc_clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         parity
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, acc_q, acc_d, y_q, y_d;
  logic [2:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic           zero_q, zero_d, parity_q, parity_d;

  logic [W-1:0]   a_eff, par_y, fin;
  logic           xfer, load, a_bit, b_bit, ser_bit;

  assign xfer  = in_valid && in_ready_q;
  // A clear on the accept edge wins over the stored accumulator
  assign a_eff = acc_sel ? (acc_clr ? '0 : acc_q) : a;

  for (genvar i = 0; i < W; i++) begin : g_par
    cl_bit u_cell (.a(a_eff[i]), .b(b[i]), .op(op), .out(par_y[i]));
  end

  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (cnt_q == CW'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
  end

  cl_bit u_ser (.a(a_bit), .b(b_bit), .op(op_q), .out(ser_bit));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    acc_d       = acc_q;
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = out_valid_q;
    fin         = '0;
    load        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_clr) acc_d = '0;
        if (xfer) begin
          a_d   = a_eff;
          b_d   = b;
          op_d  = op;
          cnt_d = '0;
          res_d = '0;
          if (ser) begin
            state_d = ST_BUSY;
          end else begin
            fin  = par_y;
            load = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < W; i++) begin
          if (cnt_q == CW'(i)) res_d[i] = ser_bit;
        end
        if (cnt_q == CW'(W - 1)) begin
          cnt_d = '0;
          fin   = res_d;
          load  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d     = ST_RESULT;
      acc_d       = fin;
      y_d         = fin;
      zero_d      = (fin == '0);
      parity_d    = ^fin;
      out_valid_d = 1'b1;
    end
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule
